// File: rtl/c3aibadapt_cmn_clkmux2_ctl.sv
// Glitch-safe 2:1 clock-mux select sequencer: gate, drain, flip select, settle, ungate, ack.
// Optional status ports (sw_drop, sw_cnt) under `C3AIBADAPT_CMN_CLKMUX2_CTL_STATUS_EN.
module c3aibadapt_cmn_clkmux2_ctl #(
  parameter int unsigned DRAIN_CYC  = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 4,
  parameter logic        RST_SEL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_req,
  input  logic       sw_sel,
  output logic       sw_ack,
  output logic       busy,
  output logic       clk_sel,
  output logic       clk_gate_en
`ifdef C3AIBADAPT_CMN_CLKMUX2_CTL_STATUS_EN
  ,
  output logic       sw_drop,
  output logic [7:0] sw_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE, GATE_OFF, DRAIN, SWITCH, SETTLE, GATE_ON, DONE
  } state_t;

  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             chg;

  // A no-change request still passes through GATE_OFF so busy rises one edge
  // before the ack; chg suppresses all gate/select activity on that path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      chg         <= 1'b0;
      sw_ack      <= 1'b0;
      busy        <= 1'b0;
      clk_sel     <= RST_SEL;
      clk_gate_en <= 1'b1;
    end else begin
      sw_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (sw_req && !sw_ack) begin
            chg   <= (sw_sel != clk_sel);
            state <= GATE_OFF;
          end
        end
        GATE_OFF: begin
          busy <= 1'b1;
          if (chg) begin
            clk_gate_en <= 1'b0;
            cnt         <= DRAIN_LD;
            state       <= DRAIN;
          end else begin
            state <= DONE;
          end
        end
        DRAIN: begin
          if (cnt == CNT_ONE) begin
            cnt   <= '0;
            state <= SWITCH;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        SWITCH: begin
          clk_sel <= ~clk_sel;
          cnt     <= SETTLE_LD;
          state   <= SETTLE;
        end
        SETTLE: begin
          if (cnt == CNT_ONE) begin
            cnt   <= '0;
            state <= GATE_ON;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        GATE_ON: begin
          clk_gate_en <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          sw_ack <= 1'b1;
          busy   <= 1'b0;
          chg    <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef C3AIBADAPT_CMN_CLKMUX2_CTL_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_drop <= 1'b0;
      sw_cnt  <= '0;
    end else begin
      if (sw_req && (state != IDLE || sw_ack)) sw_drop <= 1'b1;
      if (state == SWITCH) sw_cnt <= sw_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_c3aibadapt_cmn_clkmux2_ctl.sv
// Scoreboard bench: stimulus queues expected output transitions per edge, monitors pop and compare.
module tb_c3aibadapt_cmn_clkmux2_ctl;

  localparam int K_SEL = 0, K_GATE = 1, K_BUSY = 2, K_ACK = 3;

  typedef struct { int cyc; int kind; int val; } ev_t;
  typedef struct { int cyc; logic [3:0] v; } lv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_req = 1'b0, a_ssel = 1'b0, b_req = 1'b0, b_ssel = 1'b0;
  logic a_ack, a_busy, a_sel, a_gate;
  logic b_ack, b_busy, b_sel, b_gate;
`ifdef C3AIBADAPT_CMN_CLKMUX2_CTL_STATUS_EN
  logic       a_drop, b_drop;
  logic [7:0] a_cnt, b_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  bit en       = 1'b0;
  ev_t q_a[$], q_b[$];
  lv_t lv_a[$], lv_b[$];
  logic [3:0] prev_a, prev_b;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  c3aibadapt_cmn_clkmux2_ctl #(.DRAIN_CYC(4), .SETTLE_CYC(2), .CNT_W(4), .RST_SEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .sw_req(a_req), .sw_sel(a_ssel),
    .sw_ack(a_ack), .busy(a_busy), .clk_sel(a_sel), .clk_gate_en(a_gate)
`ifdef C3AIBADAPT_CMN_CLKMUX2_CTL_STATUS_EN
    , .sw_drop(a_drop), .sw_cnt(a_cnt)
`endif
  );

  c3aibadapt_cmn_clkmux2_ctl #(.DRAIN_CYC(1), .SETTLE_CYC(1), .CNT_W(4), .RST_SEL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .sw_req(b_req), .sw_sel(b_ssel),
    .sw_ack(b_ack), .busy(b_busy), .clk_sel(b_sel), .clk_gate_en(b_gate)
`ifdef C3AIBADAPT_CMN_CLKMUX2_CTL_STATUS_EN
    , .sw_drop(b_drop), .sw_cnt(b_cnt)
`endif
  );

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  function automatic void unexpected(input string name, input int kind, input int val);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected transition kind %0d to %0d at edge %0d, expected none",
             name, kind, val, edge_cnt);
  endfunction

  function automatic void push_ev(input bit b, input int cyc, input int kind, input int val);
    ev_t e;
    e.cyc = cyc; e.kind = kind; e.val = val;
    if (b) q_b.push_back(e); else q_a.push_back(e);
  endfunction

  function automatic void push_lv(input bit b, input int cyc, input logic [3:0] v);
    lv_t l;
    l.cyc = cyc; l.v = v;
    if (b) lv_b.push_back(l); else lv_a.push_back(l);
  endfunction

  // Full switch: gate off + busy at edge 1, select at sel_at, gate on at gon_at, ack next edge.
  function automatic void exp_switch(input bit b, input int e0, input int sel_at,
                                     input int gon_at, input int newsel);
    push_ev(b, e0 + 1, K_GATE, 0);
    push_ev(b, e0 + 1, K_BUSY, 1);
    push_ev(b, e0 + sel_at, K_SEL, newsel);
    push_ev(b, e0 + gon_at, K_GATE, 1);
    push_ev(b, e0 + gon_at + 1, K_BUSY, 0);
    push_ev(b, e0 + gon_at + 1, K_ACK, 1);
    push_ev(b, e0 + gon_at + 2, K_ACK, 0);
  endfunction

  always @(negedge clk) begin
    logic [3:0] cur;
    ev_t e;
    lv_t l;
    cur = {a_sel, a_gate, a_busy, a_ack};
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (cur[3-k] !== prev_a[3-k]) begin
          if (q_a.size() == 0) unexpected("a_event", k, int'(cur[3-k]));
          else begin
            e = q_a.pop_front();
            chk($sformatf("a_ev_edge_k%0d", k), edge_cnt, e.cyc);
            chk($sformatf("a_ev_kindval_k%0d", k), k * 2 + int'(cur[3-k]), e.kind * 2 + e.val);
          end
        end
      end
      while (lv_a.size() > 0 && lv_a[0].cyc <= edge_cnt) begin
        l = lv_a.pop_front();
        chk("a_level", int'(cur), int'(l.v));
      end
    end
    prev_a = cur;
  end

  always @(negedge clk) begin
    logic [3:0] cur;
    ev_t e;
    lv_t l;
    cur = {b_sel, b_gate, b_busy, b_ack};
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (cur[3-k] !== prev_b[3-k]) begin
          if (q_b.size() == 0) unexpected("b_event", k, int'(cur[3-k]));
          else begin
            e = q_b.pop_front();
            chk($sformatf("b_ev_edge_k%0d", k), edge_cnt, e.cyc);
            chk($sformatf("b_ev_kindval_k%0d", k), k * 2 + int'(cur[3-k]), e.kind * 2 + e.val);
          end
        end
      end
      while (lv_b.size() > 0 && lv_b[0].cyc <= edge_cnt) begin
        l = lv_b.pop_front();
        chk("b_level", int'(cur), int'(l.v));
      end
    end
    prev_b = cur;
  end

  // Called at a negedge; returns edge 0 (the edge that samples the request).
  task automatic issue(input bit b, input logic s, output int e0);
    e0 = edge_cnt + 1;
    if (b) begin b_req = 1'b1; b_ssel = s; end
    else   begin a_req = 1'b1; a_ssel = s; end
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e0;
    idle(3);
    en = 1'b1;
    rst = 1'b0;
    // 1: reset defaults, quiet idle
    push_lv(0, edge_cnt + 1, 4'b0100);
    push_lv(0, edge_cnt + 10, 4'b0100);
    push_lv(1, edge_cnt + 1, 4'b0100);
    idle(10);

    // 2: 0->1
    issue(0, 1'b1, e0);
    exp_switch(0, e0, 6, 9, 1);
    idle(12);

    // 3: no-change request, sel stays 1, gate stays 1
    issue(0, 1'b1, e0);
    push_ev(0, e0 + 1, K_BUSY, 1);
    push_ev(0, e0 + 2, K_BUSY, 0);
    push_ev(0, e0 + 2, K_ACK, 1);
    push_ev(0, e0 + 3, K_ACK, 0);
    push_lv(0, e0 + 3, 4'b1100);
    idle(5);
`ifdef C3AIBADAPT_CMN_CLKMUX2_CTL_STATUS_EN
    chk("a_drop_after_nochg", int'(a_drop), 0);
    chk("a_cnt_after_nochg", int'(a_cnt), 1);
`endif

    issue(0, 1'b0, e0);
    exp_switch(0, e0, 6, 9, 0);
    idle(12);

    // 4: request while busy (edge 3) and in the ack cycle (edge 11), both dropped
    issue(0, 1'b1, e0);
    exp_switch(0, e0, 6, 9, 1);
    idle(2);
    a_req = 1'b1; a_ssel = 1'b0;
    @(negedge clk);
    a_req = 1'b0;
    idle(7);
    a_req = 1'b1; a_ssel = 1'b0;
    @(negedge clk);
    a_req = 1'b0;
    push_lv(0, e0 + 14, 4'b1100);
    idle(4);
`ifdef C3AIBADAPT_CMN_CLKMUX2_CTL_STATUS_EN
    chk("a_drop_after_busy_req", int'(a_drop), 1);
    chk("a_cnt_after_busy_req", int'(a_cnt), 3);
`endif

    issue(0, 1'b0, e0);
    exp_switch(0, e0, 6, 9, 0);
    idle(12);

    // 5: reset asserted for the edge after edge 7
    issue(0, 1'b1, e0);
    push_ev(0, e0 + 1, K_GATE, 0);
    push_ev(0, e0 + 1, K_BUSY, 1);
    push_ev(0, e0 + 6, K_SEL, 1);
    push_ev(0, e0 + 8, K_SEL, 0);
    push_ev(0, e0 + 8, K_GATE, 1);
    push_ev(0, e0 + 8, K_BUSY, 0);
    push_lv(0, e0 + 9, 4'b0100);
    idle(7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(15);
`ifdef C3AIBADAPT_CMN_CLKMUX2_CTL_STATUS_EN
    chk("a_drop_after_rst", int'(a_drop), 0);
    chk("a_cnt_after_rst", int'(a_cnt), 0);
`endif

    // 6: minimum parameters, back-to-back 0->1->0
    issue(1, 1'b1, e0);
    exp_switch(1, e0, 3, 5, 1);
    idle(7);
    issue(1, 1'b0, e0);
    exp_switch(1, e0, 3, 5, 0);
    push_lv(1, e0 + 8, 4'b0100);
    idle(10);
`ifdef C3AIBADAPT_CMN_CLKMUX2_CTL_STATUS_EN
    chk("b_drop_final", int'(b_drop), 0);
    chk("b_cnt_final", int'(b_cnt), 2);
`endif

    chk("a_events_pending", q_a.size(), 0);
    chk("b_events_pending", q_b.size(), 0);
    chk("a_levels_pending", lv_a.size(), 0);
    chk("b_levels_pending", lv_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
